redmule_ldst_scheduler: RTL

Control-only arbiter/scheduler for the streamer's single shared TCDM port, which serves three load channels (X, W, Y) and one store channel (Z). Each cycle it picks which requester drives the port and emits the data-mux select. It tracks per-load-channel credits so the depth-4 load FIFOs can never overflow, and routes in-order read responses back to their originating channel. It sits between the streamer's per-channel HCI request signals and the memory-side port, replacing untracked dynamic muxing with credit-aware, starvation-bounded scheduling.

---
 rtl/redmule_pkg.sv | 24 ++
 rtl/redmule_ldst_route_fifo.sv | 65 ++++++
 rtl/redmule_ldst_scheduler.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/redmule_pkg.sv
// Shared RedMulE definitions used by the load/store scheduler.
//   ldst_id_e   : requester IDs on the shared TCDM port (X, W, Y loads; Z store)
//   ldst_arb_e  : arbiter state (free to arbitrate, or locked on a pending winner)
//   Ldst*       : default sizing of the scheduler
package redmule_pkg;

  localparam int unsigned LdstNumLoad   = 3;  // load requesters X, W, Y
  localparam int unsigned LdstFifoDepth = 4;  // credits per load channel
  localparam int unsigned LdstRspDepth  = 4;  // reads in flight awaiting r_valid
  localparam int unsigned LdstStarveMax = 8;  // store wins tolerated over an eligible load

  typedef enum logic [1:0] {
    LDST_X = 2'd0,
    LDST_W = 2'd1,
    LDST_Y = 2'd2,
    LDST_Z = 2'd3
  } ldst_id_e;

  typedef enum logic {
    LDST_FREE   = 1'b0,
    LDST_LOCKED = 1'b1
  } ldst_arb_e;

endpackage

// File: rtl/redmule_ldst_route_fifo.sv
// In-order FIFO of load-channel IDs, one entry per read issued to the TCDM
// port; the head tells which channel the next r_valid belongs to.
//   clk_i, rst_i, clear_i : clock, synchronous active-high reset and soft clear
//   push_i, push_data_i   : enqueue an ID (accepted when not full, or when a pop
//                           frees the slot in the same cycle)
//   pop_i                 : dequeue the head (ignored when empty)
//   head_o                : ID at the head
//   full_o, empty_o       : registered occupancy flags
module redmule_ldst_route_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/redmule_ldst_scheduler.sv
// Credit-aware scheduler for the streamer's single shared TCDM port.
// Three load channels (X, W, Y) and one store channel (Z) compete; each cycle
// one winner drives the port and sel_o steers the address/data/be muxes.
//   clk_i, rst_i, clear_i : clock, synchronous active-high reset, soft clear
//   req_i / gnt_o         : per-requester HCI request/grant (bit NumLoad = store)
//   tcdm_req_o/_gnt_i     : memory-side handshake; tcdm_wen_o = 1 for reads
//   sel_o                 : winner ID
//   tcdm_r_valid_i        : in-order read response, routed to r_valid_o
//   fifo_pop_i            : load FIFO pop, returns one credit to that channel
//   busy_o                : lock held or reads outstanding
//   err_o                 : sticky protocol/credit error
module redmule_ldst_scheduler
  import redmule_pkg::*;
#(
  parameter int unsigned NumLoad       = LdstNumLoad,
  parameter int unsigned LoadFifoDepth = LdstFifoDepth,
  parameter int unsigned RspFifoDepth  = LdstRspDepth,
  parameter int unsigned StarveMax     = LdstStarveMax
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic [NumLoad:0]             req_i,
  output logic [NumLoad:0]             gnt_o,
  output logic                         tcdm_req_o,
  input  logic                         tcdm_gnt_i,
  output logic                         tcdm_wen_o,
  output logic [$clog2(NumLoad+1)-1:0] sel_o,
  input  logic                         tcdm_r_valid_i,
  output logic [NumLoad-1:0]           r_valid_o,
  input  logic [NumLoad-1:0]           fifo_pop_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int unsigned IdW     = $clog2(NumLoad + 1);
  localparam int unsigned LoadIdW = (NumLoad > 1) ? $clog2(NumLoad) : 1;
  localparam int unsigned CntW    = $clog2(LoadFifoDepth + 1);
  localparam int unsigned StarveW = $clog2(StarveMax + 1);

  localparam logic [IdW-1:0]     StoreId   = IdW'(NumLoad);
  localparam logic [CntW-1:0]    CreditMax = CntW'(LoadFifoDepth);
  localparam logic [StarveW-1:0] StarveSat = StarveW'(StarveMax);

  ldst_arb_e                     state_q, state_d;
  logic [IdW-1:0]                lock_id_q, lock_id_d;
  logic [NumLoad-1:0][CntW-1:0]  credit_q;
  logic [LoadIdW-1:0]            rr_q;
  logic [StarveW-1:0]            starve_q;
  logic                          err_q;

  logic                          flush;
  logic [NumLoad-1:0]            load_elig;
  logic                          store_elig, any_load_elig;
  logic                          rr_found;
  logic [LoadIdW-1:0]            rr_pick;
  logic                          win_valid, lock_drop;
  logic [IdW-1:0]                win_id;
  logic                          handshake, load_hs, store_hs;
  logic [NumLoad-1:0]            credit_take;

  logic                          rsp_full, rsp_empty;
  logic [LoadIdW-1:0]            rsp_head;

  // Arbitration is suppressed while reset/clear is applied so no transfer is
  // issued whose routing state is about to be discarded.
  assign flush = rst_i | clear_i;

  // Eligibility uses the registered full flag: a same-cycle response pop does
  // not open a slot for arbitration.
  always_comb begin
    load_elig = '0;
    for (int i = 0; i < NumLoad; i++) begin
      load_elig[i] = req_i[i] && (credit_q[i] != '0) && !rsp_full;
    end
  end

  assign store_elig    = req_i[NumLoad];
  assign any_load_elig = |load_elig;

  // First eligible load at or after the round-robin pointer.
  always_comb begin
    logic [LoadIdW-1:0] cand;
    cand     = '0;
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int k = 0; k < NumLoad; k++) begin
      cand = LoadIdW'((int'(rr_q) + k) % NumLoad);
      if (!rr_found && load_elig[cand]) begin
        rr_found = 1'b1;
        rr_pick  = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q   <= LDST_FREE;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    win_valid  = 1'b0;
    win_id     = '0;
    lock_drop  = 1'b0;
    tcdm_req_o = 1'b0;
    tcdm_wen_o = 1'b1;
    sel_o      = '0;
    gnt_o      = '0;

    if (!flush) begin
      unique case (state_q)
        LDST_FREE: begin
          // The store normally wins, but yields once it has starved the loads
          // for StarveMax consecutive handshakes.
          if (store_elig && !((starve_q == StarveSat) && any_load_elig)) begin
            win_valid = 1'b1;
            win_id    = StoreId;
          end else if (rr_found) begin
            win_valid = 1'b1;
            win_id    = IdW'(rr_pick);
          end
        end
        LDST_LOCKED: begin
          // The pending winner keeps the port regardless of credits or FIFO
          // state; it was eligible when it first won.
          if (req_i[lock_id_q]) begin
            win_valid = 1'b1;
            win_id    = lock_id_q;
          end else begin
            lock_drop = 1'b1;
          end
        end
        default: ;
      endcase

      if (win_valid) begin
        tcdm_req_o     = 1'b1;
        sel_o          = win_id;
        tcdm_wen_o     = (win_id != StoreId);
        gnt_o[win_id]  = tcdm_gnt_i;
      end

      if (win_valid && !tcdm_gnt_i) begin
        state_d   = LDST_LOCKED;
        lock_id_d = win_id;
      end else if ((win_valid && tcdm_gnt_i) || lock_drop) begin
        state_d   = LDST_FREE;
      end
    end
  end

  assign handshake = win_valid && tcdm_gnt_i;
  assign load_hs   = handshake && (win_id != StoreId);
  assign store_hs  = handshake && (win_id == StoreId);

  always_comb begin
    credit_take = '0;
    for (int i = 0; i < NumLoad; i++) begin
      credit_take[i] = load_hs && (win_id == IdW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      rr_q     <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NumLoad; i++) credit_q[i] <= CreditMax;
    end else begin
      if (load_hs) begin
        rr_q     <= (win_id == IdW'(NumLoad - 1)) ? '0 : LoadIdW'(win_id + 1'b1);
        starve_q <= '0;
      end else if (store_hs && any_load_elig && (starve_q != StarveSat)) begin
        starve_q <= starve_q + 1'b1;
      end

      if (lock_drop || (tcdm_r_valid_i && rsp_empty)) err_q <= 1'b1;

      // A take and a pop on the same channel cancel out.
      for (int i = 0; i < NumLoad; i++) begin
        if (fifo_pop_i[i] && !credit_take[i]) begin
          if (credit_q[i] == CreditMax) err_q <= 1'b1;
          else                          credit_q[i] <= credit_q[i] + 1'b1;
        end else if (credit_take[i] && !fifo_pop_i[i] && (credit_q[i] != '0)) begin
          credit_q[i] <= credit_q[i] - 1'b1;
        end
      end
    end
  end

  redmule_ldst_route_fifo #(
    .Depth (RspFifoDepth),
    .Width (LoadIdW)
  ) i_route_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .push_i      (load_hs),
    .push_data_i (LoadIdW'(win_id)),
    .pop_i       (tcdm_r_valid_i && !rsp_empty),
    .head_o      (rsp_head),
    .full_o      (rsp_full),
    .empty_o     (rsp_empty)
  );

  // Responses are steered to the head channel in the same cycle.
  always_comb begin
    r_valid_o = '0;
    if (!flush && tcdm_r_valid_i && !rsp_empty) r_valid_o[rsp_head] = 1'b1;
  end

  assign busy_o = (state_q == LDST_LOCKED) || !rsp_empty;
  assign err_o  = err_q;

endmodule
